picorv_pcpi_sched: RTL and testbench
====================================

# picorv_pcpi_sched

Sequencer and arbiter that shares one core-side PCPI transaction among NUNITS execution units (base ALU/branch unit, mul/div, custom units). It presents the current instruction to all units, accepts the first unit that completes it, and returns that unit's result to the core as one registered response. If no unit claims the instruction within TIMEOUT idle cycles, it returns an illegal-instruction trap. It sits between the core's PCPI master port and the execution units.

## Interface
- XLEN, 32: data/PC width.
- NUNITS, 4: number of attached execution units (1..8); index 0 has highest priority.
- TIMEOUT, 16: idle WAIT cycles before trap (>=2).
- clock  input  1  clock; all state updates on posedge.
- reset  input  1  reset, synchronous, active-high.
- core_valid  input  1  core has an instruction outstanding (level).
- core_wb_valid  input  1  core can accept a writeback this cycle.
- core_ready  output  1  one-cycle response strobe.
- core_trap  output  1  qualifies core_ready: no unit claimed the instruction.
- core_wb_write  output  1  response writes rd.
- core_wb_data  output  XLEN  writeback value.
- core_br_enable  output  1  response redirects PC.
- core_br_nextpc  output  XLEN  redirect target.
- core_conflict  output  1  qualifies core_ready: more than one unit was ready.
- unit_valid  output  NUNITS  instruction presented to each unit.
- unit_wb_valid  output  NUNITS  core_wb_valid replicated to every unit, combinational.
- unit_ready  input  NUNITS  unit completion strobes.
- unit_busy  input  NUNITS  unit has claimed the instruction and is still computing.
- unit_wb_write  input  NUNITS  per-unit writeback flag.
- unit_br_enable  input  NUNITS  per-unit branch flag.
- unit_wb_data  input  NUNITS*XLEN  unit i occupies bits [i*XLEN +: XLEN].
- unit_br_nextpc  input  NUNITS*XLEN  same packing.

## Operation
- States: IDLE, WAIT, RESP. Reset -> IDLE. Every output is 0 in reset and in IDLE.
- IDLE: if core_valid, go to WAIT and clear the counter.
- WAIT: unit_valid = {NUNITS{core_valid}}. Evaluate in priority order:
  - core_valid low (flush): go to IDLE with no response and clear the counter.
  - any unit_ready: latch the lowest ready index i: wb_write, wb_data, br_enable and br_nextpc of unit i. Set conflict = (popcount(unit_ready) > 1). Go to RESP.
  - any unit_busy: clear the counter and stay in WAIT.
  - counter == TIMEOUT-1: latch trap=1 and all other fields 0. Go to RESP.
  - otherwise: increment the counter and stay in WAIT.
- RESP: core_ready=1 and the latched fields are driven for exactly one cycle; unit_valid=0. Then go to IDLE unconditionally.
- Fields not selected are 0. wb_data and br_nextpc are forced to 0 when the selected unit's corresponding flag is 0.
- Counter width is $clog2(TIMEOUT). The counter never wraps: it saturates into the trap transition.
- Units gate their own unit_ready with unit_wb_valid. The scheduler does not re-check wb_valid.
- A unit_ready seen outside WAIT is ignored.

## Timing
- Outputs are registered, except unit_valid and unit_wb_valid, which are decoded from state.
- Minimum latency, with core_valid seen in IDLE at cycle t:
  - unit_valid high at t+1.
  - A unit ready at t+1 gives core_ready at t+2.
  - The core may present the next instruction at t+3, so throughput is 1 instruction per 3 cycles.
- Trap: with WAIT entered at cycle w and no ready or busy, core_ready with core_trap=1 occurs at w+TIMEOUT.
- Busy extension: each cycle with any unit_busy restarts the full TIMEOUT window.
- Reset mid-WAIT or mid-RESP: state goes to IDLE and all outputs are 0 on the next cycle. No response is emitted.
- Simultaneous ready and core_valid drop in WAIT: the flush wins and the response is discarded.

## Test plan
- Single unit: core_valid at cycle 0, unit_ready[0] at cycle 2 with wb_write=1, wb_data=32'h0000_1234 -> core_ready=1 at cycle 3 with wb_data=32'h1234, trap=0, conflict=0; unit_valid low at cycle 3.
- Priority: unit_ready=4'b0110 in the same cycle, unit1 br_enable=1, nextpc=32'h100; unit2 nextpc=32'h200 -> core_br_nextpc=32'h100, core_conflict=1.
- Timeout, TIMEOUT=16: WAIT entered at cycle 1, no activity -> core_ready=core_trap=1 exactly at cycle 17, wb_write=0; IDLE at cycle 18.
- Busy extension: unit_busy[3] high for 40 cycles, then unit_ready[3] -> no trap; normal response one cycle after ready.
- Flush: core_valid dropped in WAIT while unit_ready[0]=1 -> no core_ready; state IDLE; next instruction serviced normally.
- Reset asserted in RESP -> core_ready=0 the next cycle; all outputs 0; a back-to-back instruction after reset completes with 3-cycle latency.

Source files
------------

// File: rtl/picorv_pcpi_sched_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | picorv_pcpi_sched_if : core-side PCPI and per-unit execution bus bundle   |
// | Revision: 1.0                                                             |
// +-------------------------------------------------------------------------+
interface picorv_pcpi_sched_if #(
  parameter int XLEN   = 32,
  parameter int NUNITS = 4
);
  logic                   core_valid;
  logic                   core_wb_valid;
  logic                   core_ready;
  logic                   core_trap;
  logic                   core_wb_write;
  logic [XLEN-1:0]        core_wb_data;
  logic                   core_br_enable;
  logic [XLEN-1:0]        core_br_nextpc;
  logic                   core_conflict;
  logic [NUNITS-1:0]      unit_valid;
  logic [NUNITS-1:0]      unit_wb_valid;
  logic [NUNITS-1:0]      unit_ready;
  logic [NUNITS-1:0]      unit_busy;
  logic [NUNITS-1:0]      unit_wb_write;
  logic [NUNITS-1:0]      unit_br_enable;
  logic [NUNITS*XLEN-1:0] unit_wb_data;
  logic [NUNITS*XLEN-1:0] unit_br_nextpc;

  // The scheduler sits on the slave side; the core plus units drive the master side.
  modport slave (
    input  core_valid, core_wb_valid, unit_ready, unit_busy,
           unit_wb_write, unit_br_enable, unit_wb_data, unit_br_nextpc,
    output core_ready, core_trap, core_wb_write, core_wb_data,
           core_br_enable, core_br_nextpc, core_conflict, unit_valid, unit_wb_valid
  );

  modport master (
    output core_valid, core_wb_valid, unit_ready, unit_busy,
           unit_wb_write, unit_br_enable, unit_wb_data, unit_br_nextpc,
    input  core_ready, core_trap, core_wb_write, core_wb_data,
           core_br_enable, core_br_nextpc, core_conflict, unit_valid, unit_wb_valid
  );
endinterface
`default_nettype wire

// File: rtl/picorv_pcpi_sched.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | picorv_pcpi_sched : shares one PCPI transaction among NUNITS units        |
// | Revision: 1.0                                                             |
// +-------------------------------------------------------------------------+
module picorv_pcpi_sched #(
  parameter int XLEN    = 32,
  parameter int NUNITS  = 4,
  parameter int TIMEOUT = 16
) (
  input  wire logic           clock,
  input  wire logic           reset,
  picorv_pcpi_sched_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam int IW = (NUNITS > 1) ? $clog2(NUNITS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [CW-1:0]     r_cnt;

  logic              r_ready;
  logic              r_trap;
  logic              r_wb_write;
  logic [XLEN-1:0]   r_wb_data;
  logic              r_br_enable;
  logic [XLEN-1:0]   r_br_nextpc;
  logic              r_conflict;

  logic              w_in_wait;
  logic              w_any_ready;
  logic              w_any_busy;
  logic              w_multi;
  logic              w_expired;
  logic              w_take;
  logic              w_trap;
  logic              w_inc;
  logic [IW-1:0]     w_sel;
  logic              w_sel_wbw;
  logic              w_sel_bre;
  logic [XLEN-1:0]   w_sel_data;
  logic [XLEN-1:0]   w_sel_npc;
  logic [NUNITS-1:0] w_unit_valid;
  logic [NUNITS-1:0] w_unit_wb_valid;

  assign w_in_wait   = (r_state == S_WAIT) && bus.core_valid;
  assign w_any_ready = |bus.unit_ready;
  assign w_any_busy  = |bus.unit_busy;
  // x & (x-1) is nonzero exactly when more than one bit is set.
  assign w_multi     = |(bus.unit_ready & (bus.unit_ready - NUNITS'(1)));
  assign w_expired   = (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_sel = '0;
    for (int i = NUNITS - 1; i >= 0; i--) begin
      if (bus.unit_ready[i]) w_sel = IW'(i);
    end
  end

  assign w_sel_wbw  = bus.unit_wb_write[w_sel];
  assign w_sel_bre  = bus.unit_br_enable[w_sel];
  assign w_sel_data = bus.unit_wb_data[w_sel*XLEN +: XLEN];
  assign w_sel_npc  = bus.unit_br_nextpc[w_sel*XLEN +: XLEN];

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.core_valid) w_next = S_WAIT;
      S_WAIT: begin
        if (!bus.core_valid)                      w_next = S_IDLE;
        else if (w_any_ready)                     w_next = S_RESP;
        else if (!w_any_busy && w_expired)        w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_unit_valid    = '0;
    w_unit_wb_valid = '0;
    w_take          = 1'b0;
    w_trap          = 1'b0;
    w_inc           = 1'b0;
    if (r_state == S_WAIT && !reset) begin
      w_unit_valid    = {NUNITS{bus.core_valid}};
      w_unit_wb_valid = {NUNITS{bus.core_wb_valid}};
    end
    if (w_in_wait) begin
      w_take = w_any_ready;
      w_trap = !w_any_ready && !w_any_busy && w_expired;
      w_inc  = !w_any_ready && !w_any_busy && !w_expired;
    end
  end

  // Counter only advances on idle WAIT cycles; every other path restarts it.
  always_ff @(posedge clock) begin
    if (reset || !w_inc) r_cnt <= '0;
    else                 r_cnt <= r_cnt + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ready     <= 1'b0;
      r_trap      <= 1'b0;
      r_wb_write  <= 1'b0;
      r_wb_data   <= '0;
      r_br_enable <= 1'b0;
      r_br_nextpc <= '0;
      r_conflict  <= 1'b0;
    end else begin
      r_ready     <= w_take || w_trap;
      r_trap      <= w_trap;
      r_wb_write  <= w_take && w_sel_wbw;
      r_wb_data   <= (w_take && w_sel_wbw) ? w_sel_data : '0;
      r_br_enable <= w_take && w_sel_bre;
      r_br_nextpc <= (w_take && w_sel_bre) ? w_sel_npc : '0;
      r_conflict  <= w_take && w_multi;
    end
  end

  assign bus.core_ready     = r_ready;
  assign bus.core_trap      = r_trap;
  assign bus.core_wb_write  = r_wb_write;
  assign bus.core_wb_data   = r_wb_data;
  assign bus.core_br_enable = r_br_enable;
  assign bus.core_br_nextpc = r_br_nextpc;
  assign bus.core_conflict  = r_conflict;
  assign bus.unit_valid     = w_unit_valid;
  assign bus.unit_wb_valid  = w_unit_wb_valid;
endmodule
`default_nettype wire

// File: tb/tb_picorv_pcpi_sched.sv
`default_nettype none
// tb_picorv_pcpi_sched : directed, table-driven check of the PCPI scheduler.
module tb_picorv_pcpi_sched;
  localparam int XLEN = 32;
  localparam int NU   = 4;
  localparam int TO   = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  picorv_pcpi_sched_if #(.XLEN(XLEN), .NUNITS(NU)) bus ();

  picorv_pcpi_sched #(.XLEN(XLEN), .NUNITS(NU), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string        name;
    logic [3:0]   rdy;
    logic [3:0]   wbw;
    logic [3:0]   bre;
    logic [127:0] data;
    logic [127:0] npc;
    logic         e_wbw;
    logic [31:0]  e_data;
    logic         e_bre;
    logic [31:0]  e_npc;
    logic         e_conf;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clear_units();
    bus.unit_ready     = '0;
    bus.unit_busy      = '0;
    bus.unit_wb_write  = '0;
    bus.unit_br_enable = '0;
    bus.unit_wb_data   = '0;
    bus.unit_br_nextpc = '0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"},  32'(bus.core_ready), 32'd0);
    chk({nm, "_trap"},   32'(bus.core_trap), 32'd0);
    chk({nm, "_wbw"},    32'(bus.core_wb_write), 32'd0);
    chk({nm, "_data"},   bus.core_wb_data, 32'd0);
    chk({nm, "_bre"},    32'(bus.core_br_enable), 32'd0);
    chk({nm, "_npc"},    bus.core_br_nextpc, 32'd0);
    chk({nm, "_conf"},   32'(bus.core_conflict), 32'd0);
    chk({nm, "_uvalid"}, 32'(bus.unit_valid), 32'd0);
    chk({nm, "_uwbv"},   32'(bus.unit_wb_valid), 32'd0);
  endtask

  // Issue one instruction from IDLE, present the vector's unit response in WAIT.
  task automatic run_vec(input int k);
    bus.core_valid = 1'b1;
    tick();
    chk({vecs[k].name, "_uvalid"}, 32'(bus.unit_valid), 32'hF);
    chk({vecs[k].name, "_uwbv"},   32'(bus.unit_wb_valid), 32'hF);
    chk({vecs[k].name, "_early"},  32'(bus.core_ready), 32'd0);
    bus.unit_ready     = vecs[k].rdy;
    bus.unit_wb_write  = vecs[k].wbw;
    bus.unit_br_enable = vecs[k].bre;
    bus.unit_wb_data   = vecs[k].data;
    bus.unit_br_nextpc = vecs[k].npc;
    tick();
    chk({vecs[k].name, "_ready"},  32'(bus.core_ready), 32'd1);
    chk({vecs[k].name, "_trap"},   32'(bus.core_trap), 32'd0);
    chk({vecs[k].name, "_wbw"},    32'(bus.core_wb_write), 32'(vecs[k].e_wbw));
    chk({vecs[k].name, "_data"},   bus.core_wb_data, vecs[k].e_data);
    chk({vecs[k].name, "_bre"},    32'(bus.core_br_enable), 32'(vecs[k].e_bre));
    chk({vecs[k].name, "_npc"},    bus.core_br_nextpc, vecs[k].e_npc);
    chk({vecs[k].name, "_conf"},   32'(bus.core_conflict), 32'(vecs[k].e_conf));
    chk({vecs[k].name, "_uvresp"}, 32'(bus.unit_valid), 32'd0);
    clear_units();
    bus.core_valid = 1'b0;
    tick();
    chk({vecs[k].name, "_idle"}, 32'(bus.core_ready), 32'd0);
  endtask

  initial begin
    int  lat;
    logic seen;

    vecs[0] = '{"single", 4'b0001, 4'b0001, 4'b0000,
                {32'h0, 32'h0, 32'h0, 32'h0000_1234}, 128'h0,
                1'b1, 32'h0000_1234, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{"prio", 4'b0110, 4'b0000, 4'b0110,
                {32'h0, 32'h0, 32'h0000_DEAD, 32'h0},
                {32'h0, 32'h0000_0200, 32'h0000_0100, 32'h0},
                1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b1};
    vecs[2] = '{"unit3", 4'b1000, 4'b1000, 4'b1000,
                {32'hCAFE_F00D, 32'h0, 32'h0, 32'h0},
                {32'h8000_0004, 32'h0, 32'h0, 32'h0},
                1'b1, 32'hCAFE_F00D, 1'b1, 32'h8000_0004, 1'b0};
    vecs[3] = '{"all4", 4'b1111, 4'b1110, 4'b1110,
                {32'h1, 32'h2, 32'h3, 32'h55},
                {32'h4, 32'h5, 32'h6, 32'h66},
                1'b0, 32'h0, 1'b0, 32'h0, 1'b1};
    vecs[4] = '{"npcmask", 4'b0100, 4'b0100, 4'b0000,
                {32'h0, 32'hA5A5_0000, 32'h0, 32'h0},
                {32'h0, 32'h0000_0444, 32'h0, 32'h0},
                1'b1, 32'hA5A5_0000, 1'b0, 32'h0, 1'b0};

    bus.core_valid    = 1'b0;
    bus.core_wb_valid = 1'b1;
    clear_units();
    reset = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk_all_zero("idle");

    // Ready strobes while IDLE must not produce a response.
    bus.unit_ready = 4'b1111;
    tick();
    chk("ign_idle", 32'(bus.core_ready), 32'd0);
    clear_units();
    tick();

    for (int k = 0; k < 5; k++) run_vec(k);

    // Timeout: WAIT entered, no activity, trap exactly TO cycles later.
    bus.core_valid = 1'b1;
    tick();
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.core_ready) begin
        lat = c;
        break;
      end
    end
    chk("to_latency", 32'(lat), 32'(TO));
    chk("to_trap", 32'(bus.core_trap), 32'd1);
    chk("to_wbw", 32'(bus.core_wb_write), 32'd0);
    chk("to_conf", 32'(bus.core_conflict), 32'd0);
    bus.core_valid = 1'b0;
    tick();
    chk("to_idle", 32'(bus.core_ready), 32'd0);

    // Busy extends the window well past TO.
    bus.core_valid = 1'b1;
    tick();
    bus.unit_busy = 4'b1000;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (bus.core_ready) seen = 1'b1;
    end
    chk("busy_no_resp", 32'(seen), 32'd0);
    bus.unit_busy     = '0;
    bus.unit_ready    = 4'b1000;
    bus.unit_wb_write = 4'b1000;
    bus.unit_wb_data  = {32'h0000_0077, 96'h0};
    tick();
    chk("busy_ready", 32'(bus.core_ready), 32'd1);
    chk("busy_trap", 32'(bus.core_trap), 32'd0);
    chk("busy_data", bus.core_wb_data, 32'h0000_0077);
    clear_units();
    bus.core_valid = 1'b0;
    tick();

    // Flush wins over a simultaneous ready.
    bus.core_valid = 1'b1;
    tick();
    bus.core_valid    = 1'b0;
    bus.unit_ready    = 4'b0001;
    bus.unit_wb_write = 4'b0001;
    bus.unit_wb_data  = {96'h0, 32'h0000_0005};
    tick();
    chk("flush_ready", 32'(bus.core_ready), 32'd0);
    chk("flush_uvalid", 32'(bus.unit_valid), 32'd0);
    clear_units();
    tick();
    chk("flush_after", 32'(bus.core_ready), 32'd0);
    run_vec(0);

    // Reset during RESP clears outputs on the next cycle.
    bus.core_valid = 1'b1;
    tick();
    bus.unit_ready    = 4'b0001;
    bus.unit_wb_write = 4'b0001;
    bus.unit_wb_data  = {96'h0, 32'h0000_0099};
    tick();
    chk("rresp_ready", 32'(bus.core_ready), 32'd1);
    clear_units();
    reset = 1'b1;
    tick();
    chk_all_zero("rresp");

    // Reset during WAIT with a ready present: no response.
    reset = 1'b0;
    tick();
    bus.unit_ready    = 4'b0001;
    bus.unit_wb_write = 4'b0001;
    bus.unit_wb_data  = {96'h0, 32'h0000_0042};
    reset = 1'b1;
    tick();
    chk_all_zero("rwait");
    reset = 1'b0;
    clear_units();
    bus.core_valid = 1'b0;
    tick();
    chk("rwait_after", 32'(bus.core_ready), 32'd0);
    run_vec(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
